// File: rtl/button_debounce_multi.sv
// -----------------------------------------------------------------------------
// button_debounce_multi
//
// N-channel push-button conditioner for the slow system clock domain. Each
// channel is independent and has:
//   - a 2-FF synchroniser on the raw button input,
//   - a stability-counter debouncer that accepts a new level only after
//     STABLE_CYCLES consecutive synchronised samples disagree with the current
//     debounced level,
//   - one-cycle press / release pulses, registered on the edge where the level
//     changes,
//   - an optional long-press pulse, fired once per press after the debounced
//     level has been held high for LONG_CYCLES cycles.
//
// Optional feature macro: LONG_PRESS_EN
//   defined   -> per-channel hold counter and long_press pulse generation.
//   undefined -> no hold counter; long_press is tied to 0 (port list unchanged).
//
// Parameters
//   N_BTN          number of button channels (>= 1)
//   STABLE_CYCLES  consecutive synchronised cycles needed to accept a level (>= 1)
//   LONG_CYCLES    hold time for long_press, in cycles (> STABLE_CYCLES)
//   CNT_W          hold counter width, derived from LONG_CYCLES (do not override)
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   btn            raw asynchronous button inputs, 1 = pressed
//   level          debounced button state
//   press_pulse    one-cycle pulse on a debounced 0->1 transition
//   release_pulse  one-cycle pulse on a debounced 1->0 transition
//   long_press     one-cycle pulse after LONG_CYCLES of continuous hold
// -----------------------------------------------------------------------------
module button_debounce_multi #(
  parameter int N_BTN         = 4,
  parameter int STABLE_CYCLES = 5,
  parameter int LONG_CYCLES   = 500,
  parameter int CNT_W         = $clog2(LONG_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press
);

  // Debounce counter only has to reach STABLE_CYCLES-1.
  localparam int DB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(STABLE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // ---------------------------------------------------------------------------
  if (N_BTN < 1) begin : g_bad_n_btn
    $error("button_debounce_multi: N_BTN must be >= 1");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("button_debounce_multi: STABLE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES <= STABLE_CYCLES) begin : g_bad_long
    $error("button_debounce_multi: LONG_CYCLES must exceed STABLE_CYCLES");
  end
  if (CNT_W != $clog2(LONG_CYCLES + 1)) begin : g_bad_cnt_w
    $error("button_debounce_multi: CNT_W is derived and must not be overridden");
  end

  // ---------------------------------------------------------------------------
  // 2-FF synchroniser, shared across channels. Only s2 feeds the debouncers.
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours (s2 gets the old s1).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel debounce, edge pulses and optional long-press detection
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N_BTN; g++) begin : g_ch

    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_nxt;
    logic            level_q;
    logic            level_nxt;
    logic            press_q;
    logic            release_q;
    logic            differs;
    logic            accept;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
      differs    = s2[g] ^ level_q;
      accept     = differs && (db_cnt == DB_LAST);
      db_cnt_nxt = '0;
      level_nxt  = level_q;
      if (accept) begin
        // Input has disagreed for STABLE_CYCLES samples: take the new level.
        level_nxt  = s2[g];
        db_cnt_nxt = '0;
      end else if (differs) begin
        db_cnt_nxt = db_cnt + DB_ONE;
      end
      // s2 == level falls through with db_cnt_nxt = 0, so any glitch shorter
      // than STABLE_CYCLES samples simply restarts the count.
    end

    // NOTE: every counter and flag is reset here, so a reset in the middle of a
    // debounce window discards the partial count and cannot emit a pulse.
    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        db_cnt    <= db_cnt_nxt;
        level_q   <= level_nxt;
        // Pulses are registered on the same edge the level changes, and can
        // never both be set because level_nxt differs from level_q one way only.
        press_q   <= accept &&  s2[g];
        release_q <= accept && !s2[g];
      end
    end

    assign level[g]         = level_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = release_q;

`ifdef LONG_PRESS_EN
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_PRE = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

    logic [CNT_W-1:0] hold_cnt;
    logic             long_q;

    // hold_cnt is held at 0 while released and during the press_pulse cycle,
    // then counts once per cycle of continuous hold and parks at HOLD_MAX.
    // Parking there is what limits long_press to one pulse per press; a
    // release before HOLD_MAX clears the count without a pulse.
    always_ff @(posedge clk) begin
      if (rst) begin
        hold_cnt <= '0;
        long_q   <= 1'b0;
      end else begin
        long_q <= 1'b0;
        if (!level_q || press_q) begin
          hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + HOLD_ONE;
          long_q   <= (hold_cnt == HOLD_PRE);
        end
      end
    end

    assign long_press[g] = long_q;
`else
    assign long_press[g] = 1'b0;
`endif

  end : g_ch

endmodule : button_debounce_multi
